// File: rtl/cursor_draw_ctrl_pkg.sv
// cursor_draw_ctrl_pkg: shared image geometry, key indices and FSM encoding
package cursor_draw_ctrl_pkg;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIXELS = IMG_W * IMG_H;
  localparam int INK = 1;
  localparam int NKEYS = 7;
  localparam int K_UP = 0;
  localparam int K_DOWN = 1;
  localparam int K_LEFT = 2;
  localparam int K_RIGHT = 3;
  localparam int K_DRAW = 4;
  localparam int K_ERASE = 5;
  localparam int K_CLEAR = 6;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic logic [9:0] pix_addr(input logic [4:0] x, input logic [4:0] y);
    return 10'(y) * 10'(IMG_W) + 10'(x);
  endfunction
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: 2-flop synchronizer plus rising-edge detect for N raw keys
module key_edge_detect #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] keys,
  output logic [N-1:0] level,
  output logic [N-1:0] rise
);
  logic [N-1:0] s1, s2, prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      prev <= s2;
    end
  assign level = s2;
  assign rise = s2 & ~prev;
endmodule

// File: rtl/cursor_draw_ctrl.sv
// cursor_draw_ctrl: push-button cursor that issues pixel writes and full-frame clear sweeps
module cursor_draw_ctrl
  import cursor_draw_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_up,
  input  logic                     key_down,
  input  logic                     key_left,
  input  logic                     key_right,
  input  logic                     key_draw,
  input  logic                     key_erase,
  input  logic                     key_clear,
  output logic [ADDR_W-1:0]        write_addr,
  output logic signed [DATA_W-1:0] data_in,
  output logic                     write_enable,
  output logic [4:0]               cursor_x,
  output logic [4:0]               cursor_y,
  output logic                     busy
);
  logic [NKEYS-1:0] lvl, ev;
  state_t state, state_n;
  logic [9:0] addr_q, addr_n;
  logic signed [DATA_W-1:0] data_q, data_n;
  logic we_q, we_n, paint_q, paint_n;
  logic [4:0] cx_q, cx_n, cy_q, cy_n;
  logic unused_lvl;
  key_edge_detect #(.N(NKEYS)) u_keys (
    .clk(clk),
    .reset(reset),
    .keys({key_clear, key_erase, key_draw, key_right, key_left, key_down, key_up}),
    .level(lvl),
    .rise(ev)
  );
  assign unused_lvl = ^{lvl[6:5], lvl[3:0]};
  always_comb begin
    state_n = state;
    addr_n = addr_q;
    data_n = data_q;
    we_n = 1'b0;
    cx_n = cx_q;
    cy_n = cy_q;
    paint_n = 1'b0;
    if (state == CLEAR) begin
      we_n = addr_q != 10'(PIXELS - 1);
      state_n = we_n ? CLEAR : IDLE;
      addr_n = we_n ? addr_q + 10'd1 : addr_q;
    end else if (ev[K_CLEAR]) begin
      state_n = CLEAR;
      we_n = 1'b1;
      addr_n = '0;
      data_n = '0;
    end else begin
      cx_n = (ev[K_RIGHT] && !ev[K_LEFT] && cx_q != 5'(IMG_W - 1)) ? cx_q + 5'd1 :
             (ev[K_LEFT] && !ev[K_RIGHT] && cx_q != 5'd0) ? cx_q - 5'd1 : cx_q;
      cy_n = (ev[K_DOWN] && !ev[K_UP] && cy_q != 5'(IMG_H - 1)) ? cy_q + 5'd1 :
             (ev[K_UP] && !ev[K_DOWN] && cy_q != 5'd0) ? cy_q - 5'd1 : cy_q;
      we_n = ev[K_DRAW] | ev[K_ERASE] | paint_q;
      addr_n = we_n ? pix_addr(cx_q, cy_q) : addr_q;
      data_n = (ev[K_DRAW] || (paint_q && !ev[K_ERASE])) ? DATA_W'(INK) : we_n ? '0 : data_q;
      // a held draw key paints the destination pixel of a real move one cycle later
      paint_n = lvl[K_DRAW] && !ev[K_DRAW] && (cx_n != cx_q || cy_n != cy_q);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      cx_q <= '0;
      cy_q <= '0;
      paint_q <= 1'b0;
    end else begin
      state <= state_n;
      addr_q <= addr_n;
      data_q <= data_n;
      we_q <= we_n;
      cx_q <= cx_n;
      cy_q <= cy_n;
      paint_q <= paint_n;
    end
  assign write_addr = ADDR_W'(addr_q);
  assign data_in = data_q;
  assign write_enable = we_q;
  assign cursor_x = cx_q;
  assign cursor_y = cy_q;
  assign busy = state == CLEAR;
endmodule

// File: tb/tb_cursor_draw_ctrl.sv
// tb_cursor_draw_ctrl: directed scenarios for the cursor/draw/clear controller
module tb_cursor_draw_ctrl;
  localparam logic [6:0] UP = 7'd1, DOWN = 7'd2, LEFT = 7'd4, RIGHT = 7'd8;
  localparam logic [6:0] DRAW = 7'd16, ERASE = 7'd32, CLR = 7'd64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] k = '0, held = '0;
  logic [15:0] write_addr;
  logic signed [31:0] data_in;
  logic write_enable, busy;
  logic [4:0] cursor_x, cursor_y;
  int checks = 0, failures = 0, busy_cnt = 0;
  logic [15:0] qa[$];
  logic signed [31:0] qd[$];

  cursor_draw_ctrl dut (
    .clk(clk), .reset(reset),
    .key_up(k[0]), .key_down(k[1]), .key_left(k[2]), .key_right(k[3]),
    .key_draw(k[4]), .key_erase(k[5]), .key_clear(k[6]),
    .write_addr(write_addr), .data_in(data_in), .write_enable(write_enable),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable) begin
      qa.push_back(write_addr);
      qd.push_back(data_in);
    end
    if (busy) busy_cnt++;
  end

  task automatic clr_log();
    @(posedge clk);
    #1;
    qa.delete();
    qd.delete();
    busy_cnt = 0;
  endtask

  task automatic press(input logic [6:0] m);
    @(negedge clk);
    k = m | held;
    repeat (4) @(negedge clk);
    k = held;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({write_addr, data_in, write_enable, cursor_x, cursor_y, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%0d data=%0d we=%0b x=%0d y=%0d busy=%0b want all 0",
               write_addr, data_in, write_enable, cursor_x, cursor_y, busy);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (write_enable !== 1'b0) begin
      failures++;
      $display("FAIL idle_we got=%0b want=0", write_enable);
    end
  endtask

  task automatic test_draw_latency();
    repeat (3) press(RIGHT);
    repeat (2) press(DOWN);
    checks++;
    if (cursor_x !== 5'd3 || cursor_y !== 5'd2) begin
      failures++;
      $display("FAIL move_pos got=(%0d,%0d) want=(3,2)", cursor_x, cursor_y);
    end
    clr_log();
    @(negedge clk);
    k = DRAW;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (write_enable !== 1'b0) begin
      failures++;
      $display("FAIL draw_early got we=%0b want=0", write_enable);
    end
    @(posedge clk);
    #1;
    checks++;
    if (write_enable !== 1'b1 || write_addr !== 16'd59 || data_in !== 32'sd1) begin
      failures++;
      $display("FAIL draw_strobe got we=%0b addr=%0d data=%0d want we=1 addr=59 data=1",
               write_enable, write_addr, data_in);
    end
    @(posedge clk);
    #1;
    checks++;
    if (write_enable !== 1'b0 || write_addr !== 16'd59 || data_in !== 32'sd1) begin
      failures++;
      $display("FAIL draw_hold got we=%0b addr=%0d data=%0d want we=0 addr=59 data=1",
               write_enable, write_addr, data_in);
    end
    @(negedge clk);
    k = '0;
    repeat (6) @(negedge clk);
    checks++;
    if (qa.size() != 1) begin
      failures++;
      $display("FAIL draw_count got=%0d want=1", qa.size());
    end
  endtask

  task automatic test_saturate();
    repeat (3) press(LEFT);
    repeat (2) press(UP);
    clr_log();
    press(LEFT | UP);
    checks++;
    if (cursor_x !== 5'd0 || cursor_y !== 5'd0 || qa.size() != 0) begin
      failures++;
      $display("FAIL sat_low got=(%0d,%0d) strobes=%0d want=(0,0) strobes=0", cursor_x, cursor_y, qa.size());
    end
    repeat (30) press(RIGHT);
    checks++;
    if (cursor_x !== 5'd27 || cursor_y !== 5'd0 || qa.size() != 0) begin
      failures++;
      $display("FAIL sat_high got=(%0d,%0d) strobes=%0d want=(27,0) strobes=0", cursor_x, cursor_y, qa.size());
    end
  endtask

  task automatic test_paint();
    repeat (22) press(LEFT);
    repeat (5) press(DOWN);
    clr_log();
    held = DRAW;
    @(negedge clk);
    k = held;
    repeat (6) @(negedge clk);
    repeat (2) press(RIGHT);
    checks++;
    if (qa.size() != 3) begin
      failures++;
      $display("FAIL paint_count got=%0d want=3", qa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (qa[i] !== 16'(145 + i) || qd[i] !== 32'sd1) begin
          failures++;
          $display("FAIL paint_%0d got addr=%0d data=%0d want addr=%0d data=1", i, qa[i], qd[i], 145 + i);
        end
      end
    end
    held = '0;
    @(negedge clk);
    k = '0;
    repeat (4) @(negedge clk);
    repeat (20) press(RIGHT);
    clr_log();
    held = DRAW;
    @(negedge clk);
    k = held;
    repeat (6) @(negedge clk);
    checks++;
    if (qa.size() != 1 || qa[0] !== 16'd167) begin
      failures++;
      $display("FAIL edge_draw got count=%0d addr=%0d want count=1 addr=167", qa.size(), qa.size() ? qa[0] : 16'hffff);
    end
    clr_log();
    press(RIGHT);
    checks++;
    if (qa.size() != 0 || cursor_x !== 5'd27) begin
      failures++;
      $display("FAIL blocked_paint got strobes=%0d x=%0d want strobes=0 x=27", qa.size(), cursor_x);
    end
    held = '0;
    @(negedge clk);
    k = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clear();
    int bad;
    clr_log();
    @(negedge clk);
    k = CLR;
    repeat (4) @(negedge clk);
    k = '0;
    repeat (100) @(negedge clk);
    k = DRAW;
    repeat (4) @(negedge clk);
    k = CLR;
    repeat (4) @(negedge clk);
    k = '0;
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (busy_cnt != 784 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_busy got cycles=%0d busy=%0b want cycles=784 busy=0", busy_cnt, busy);
    end
    checks++;
    if (qa.size() != 784) begin
      failures++;
      $display("FAIL clear_count got=%0d want=784", qa.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 784; i++) if (qa[i] !== 16'(i) || qd[i] !== 32'sd0) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL clear_sweep got bad_entries=%0d want=0", bad);
      end
    end
    checks++;
    if (cursor_x !== 5'd27 || cursor_y !== 5'd5) begin
      failures++;
      $display("FAIL clear_cursor got=(%0d,%0d) want=(27,5)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_cancel();
    press(LEFT);
    clr_log();
    press(LEFT | RIGHT);
    checks++;
    if (cursor_x !== 5'd26 || qa.size() != 0) begin
      failures++;
      $display("FAIL cancel_x got x=%0d strobes=%0d want x=26 strobes=0", cursor_x, qa.size());
    end
    press(DRAW | ERASE);
    checks++;
    if (qa.size() != 1 || qa[0] !== 16'd166 || qd[0] !== 32'sd1) begin
      failures++;
      $display("FAIL draw_erase got count=%0d addr=%0d data=%0d want count=1 addr=166 data=1",
               qa.size(), qa.size() ? qa[0] : 16'hffff, qa.size() ? qd[0] : -32'sd1);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    @(negedge clk);
    k = CLR;
    repeat (4) @(negedge clk);
    k = '0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (busy && write_addr == 16'd300) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_300 got timeout want sweep at 300");
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({write_addr, data_in, write_enable, cursor_x, cursor_y, busy} !== '0) begin
      failures++;
      $display("FAIL mid_reset got addr=%0d data=%0d we=%0b x=%0d y=%0d busy=%0b want all 0",
               write_addr, data_in, write_enable, cursor_x, cursor_y, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clr_log();
    repeat (20) @(negedge clk);
    checks++;
    if (qa.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got strobes=%0d busy=%0b want strobes=0 busy=0", qa.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_draw_latency();
    test_saturate();
    test_paint();
    test_clear();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
